// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg : shared types and stage indices for pipeline_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } dmem_state_e;

   localparam int unsigned STG_IF = 0;
   localparam int unsigned STG_ID = 1;
   localparam int unsigned STG_EX = 2;

   // Counters are held at the widest supported width and masked down to CNT_WIDTH.
   localparam int unsigned PERF_CNT_MAX_W = 64;

   typedef struct packed {
      logic [PERF_CNT_MAX_W-1:0] cycle;
      logic [PERF_CNT_MAX_W-1:0] instret;
      logic [PERF_CNT_MAX_W-1:0] stall;
      logic [PERF_CNT_MAX_W-1:0] flush;
   } perf_cnt_s;

   function automatic int unsigned stg_mem(input int unsigned num_stages);
      return num_stages - 2;
   endfunction

   function automatic int unsigned stg_wb(input int unsigned num_stages);
      return num_stages - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_hs_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_hs_fsm : data-memory req/gnt/rvalid handshake with sticky protocol error
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_hs_fsm
   import pipeline_ctrl_pkg::*;
(
   input  logic clk,
   input  logic arst_n,
   input  logic i_mem_pend,
   input  logic i_mem_we,
   input  logic i_dmem_gnt,
   input  logic i_dmem_rvalid,
   output logic o_dmem_req,
   output logic o_done,
   output logic o_proto_err
);

   dmem_state_e r_state;
   dmem_state_e w_state_nxt;
   logic        w_err;
   logic        r_proto_err;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= IDLE;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_proto_err <= r_proto_err | w_err;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_dmem_req  = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         IDLE: begin
            o_dmem_req = i_mem_pend;
            if (i_mem_pend && i_dmem_gnt) begin
               if (i_mem_we) o_done      = 1'b1;
               else          w_state_nxt = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (i_dmem_rvalid) begin
               o_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      w_err = ((r_state == IDLE) && i_dmem_rvalid)
            | ((r_state == WAIT_RSP) && i_dmem_gnt)
            | (i_dmem_gnt && !o_dmem_req);
      // A violating cycle neither advances the handshake nor completes an access.
      if (w_err) begin
         w_state_nxt = r_state;
         o_done      = 1'b0;
      end
   end

   assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_ctrl : stall/flush priority, MEM handshake and performance counters
// Rev 1.0
// ---------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [NUM_STAGES-1:0] stage_valid_i,
   input  logic                  imem_ready_i,
   input  logic                  load_use_i,
   input  logic                  mispredict_i,
   input  logic                  mem_op_i,
   input  logic                  mem_we_i,
   input  logic                  dmem_gnt_i,
   input  logic                  dmem_rvalid_i,
   input  logic                  cnt_clr_i,
   output logic [NUM_STAGES-1:0] stage_en_o,
   output logic [NUM_STAGES-1:0] stage_flush_o,
   output logic                  dmem_req_o,
   output logic                  pc_redirect_o,
   output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
   output logic [CNT_WIDTH-1:0]  instret_cnt_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
   output logic [CNT_WIDTH-1:0]  flush_cnt_o,
   output logic                  proto_err_o
);

   localparam int unsigned STG_MEM = stg_mem(NUM_STAGES);
   localparam int unsigned STG_WB  = stg_wb(NUM_STAGES);
   localparam logic [PERF_CNT_MAX_W-1:0] CNT_MASK =
      (CNT_WIDTH >= PERF_CNT_MAX_W) ? '1 : ((64'd1 << CNT_WIDTH) - 64'd1);

   logic                  w_mem_pend;
   logic                  w_mem_done;
   logic                  w_mem_stall;
   logic                  w_mispred_acc;
   logic [NUM_STAGES-1:0] w_en;
   logic [NUM_STAGES-1:0] w_flush;
   perf_cnt_s             r_perf;

   assign w_mem_pend  = stage_valid_i[STG_MEM] & mem_op_i;
   assign w_mem_stall = w_mem_pend & ~w_mem_done;

   dmem_hs_fsm u_dmem_hs_fsm (
      .clk           (clk),
      .arst_n        (arst_n),
      .i_mem_pend    (w_mem_pend),
      .i_mem_we      (mem_we_i),
      .i_dmem_gnt    (dmem_gnt_i),
      .i_dmem_rvalid (dmem_rvalid_i),
      .o_dmem_req    (dmem_req_o),
      .o_done        (w_mem_done),
      .o_proto_err   (proto_err_o)
   );

   always_comb begin
      w_en          = '1;
      w_flush       = '0;
      w_mispred_acc = 1'b0;
      if (w_mem_stall) begin
         // Everything up to and including MEM holds; WB receives a bubble.
         w_en[STG_MEM:0] = '0;
         w_flush[STG_WB] = 1'b1;
      end else if (mispredict_i) begin
         w_flush[STG_ID] = 1'b1;
         w_flush[STG_EX] = 1'b1;
         w_mispred_acc   = 1'b1;
      end else if (load_use_i) begin
         w_en[STG_ID:STG_IF] = '0;
         w_flush[STG_EX]     = 1'b1;
      end else if (!imem_ready_i) begin
         w_en[STG_IF]    = 1'b0;
         w_flush[STG_ID] = 1'b1;
      end
   end

   assign stage_en_o    = w_en;
   assign stage_flush_o = w_flush;
   assign pc_redirect_o = w_mispred_acc;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_perf <= '0;
      end else if (cnt_clr_i) begin
         r_perf <= '0;
      end else begin
         r_perf.cycle   <= (r_perf.cycle + 64'd1) & CNT_MASK;
         r_perf.instret <= (r_perf.instret + {63'd0, stage_valid_i[STG_WB]}) & CNT_MASK;
         r_perf.stall   <= (r_perf.stall + {63'd0, ~w_en[STG_IF]}) & CNT_MASK;
         r_perf.flush   <= (r_perf.flush + {63'd0, w_mispred_acc}) & CNT_MASK;
      end
   end

   assign cycle_cnt_o   = r_perf.cycle[CNT_WIDTH-1:0];
   assign instret_cnt_o = r_perf.instret[CNT_WIDTH-1:0];
   assign stall_cnt_o   = r_perf.stall[CNT_WIDTH-1:0];
   assign flush_cnt_o   = r_perf.flush[CNT_WIDTH-1:0];

endmodule
`default_nettype wire
